// File: rtl/if_stage.sv
// Purpose : instruction fetch stage; owns the PC and feeds the IF/ID register toward decode.
// Latency : an instruction reaches pipe_* one cycle after imem_valid accepts its request.
// Backpr. : stall freezes the PC and IF/ID; a response arriving under stall is parked until release.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000,
    parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        control_j,
    input  logic [31:0] pc_j,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_valid,
    input  logic [31:0] imem_data,
    output logic [31:0] pipe_pc,
    output logic [31:0] pipe_pc4,
    output logic [31:0] pipe_data,
    output logic        pipe_valid
);

    // FETCH: request outstanding at pc_q.
    // HOLD : response captured while decode was stalled; no request on the bus.
    // DROP : redirect arrived mid-request; keep the old address stable and bin its response.
    typedef enum logic [1:0] {
        FETCH = 2'd0,
        HOLD  = 2'd1,
        DROP  = 2'd2
    } state_t;

    // IF/ID pipeline register contents.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] pc4;
        logic [31:0] dat;
        logic        vld;
    } ifid_t;

    state_t      state_q,     state_d;
    logic [31:0] pc_q,        pc_d;
    logic [31:0] drop_addr_q, drop_addr_d;
    logic [31:0] buf_q,       buf_d;
    ifid_t       pipe_q,      pipe_d;

    logic [31:0] pc_inc;
    logic [31:0] jmp_target;

    // PC arithmetic wraps modulo 2^32; redirect targets are forced word-aligned.
    assign pc_inc     = pc_q + 32'd4;
    assign jmp_target = pc_j & 32'hFFFF_FFFC;

    // Memory-side outputs: the bus is idle in HOLD and while reset is asserted.
    always_comb begin
        imem_req  = reset_n && (state_q != HOLD);
        imem_addr = (state_q == DROP) ? drop_addr_q : pc_q;
    end

    // Next-state, PC and IF/ID update; redirect outranks stall everywhere.
    always_comb begin
        state_d     = state_q;
        pc_d        = pc_q;
        drop_addr_d = drop_addr_q;
        buf_d       = buf_q;
        pipe_d      = pipe_q;

        case (state_q)
            FETCH: begin
                if (control_j) begin
                    pipe_d.dat = NOP_INST;
                    pipe_d.vld = 1'b0;
                    pc_d       = jmp_target;
                    if (!imem_valid) begin
                        // Request still in flight: remember its address so it stays stable.
                        drop_addr_d = pc_q;
                        state_d     = DROP;
                    end
                end else if (imem_valid) begin
                    pc_d = pc_inc;
                    if (!stall) begin
                        pipe_d.pc  = pc_q;
                        pipe_d.pc4 = pc_inc;
                        pipe_d.dat = imem_data;
                        pipe_d.vld = 1'b1;
                    end else begin
                        // Park the instruction; pc_q moves only when it is handed to decode.
                        pc_d    = pc_q;
                        buf_d   = imem_data;
                        state_d = HOLD;
                    end
                end else if (!stall) begin
                    // Memory wait: push a bubble, keep the last PC visible.
                    pipe_d.dat = NOP_INST;
                    pipe_d.vld = 1'b0;
                end
            end

            HOLD: begin
                if (control_j) begin
                    pipe_d.dat = NOP_INST;
                    pipe_d.vld = 1'b0;
                    pc_d       = jmp_target;
                    state_d    = FETCH;
                end else if (!stall) begin
                    pipe_d.pc  = pc_q;
                    pipe_d.pc4 = pc_inc;
                    pipe_d.dat = buf_q;
                    pipe_d.vld = 1'b1;
                    pc_d       = pc_inc;
                    state_d    = FETCH;
                end
            end

            DROP: begin
                // Pipe was flushed on entry; nothing real can enter until FETCH resumes.
                pipe_d.dat = NOP_INST;
                pipe_d.vld = 1'b0;
                if (control_j) begin
                    pc_d = jmp_target;
                end
                if (imem_valid) begin
                    state_d = FETCH;
                end
            end

            default: begin
                state_d = FETCH;
            end
        endcase
    end

    // State registers with synchronous active-low reset.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q     <= FETCH;
            pc_q        <= RESET_PC;
            drop_addr_q <= 32'd0;
            buf_q       <= 32'd0;
            pipe_q.pc   <= 32'd0;
            pipe_q.pc4  <= 32'd0;
            pipe_q.dat  <= NOP_INST;
            pipe_q.vld  <= 1'b0;
        end else begin
            state_q     <= state_d;
            pc_q        <= pc_d;
            drop_addr_q <= drop_addr_d;
            buf_q       <= buf_d;
            pipe_q      <= pipe_d;
        end
    end

    assign pipe_pc    = pipe_q.pc;
    assign pipe_pc4   = pipe_q.pc4;
    assign pipe_data  = pipe_q.dat;
    assign pipe_valid = pipe_q.vld;

endmodule

// File: doc/if_stage.md
Name: if_stage

Overview:
- Instruction-fetch stage sitting directly upstream of the decode stage.
- Owns the program counter and issues one-outstanding-request fetches to instruction memory over a req/valid handshake.
- Registers {pc, pc+4, instruction} into the IF/ID pipeline outputs pipe_pc, pipe_pc4 and pipe_data.
- Consumes the decode stage's redirect (control_j, pc_j) and the hazard stall; inserts NOP bubbles on flush or memory wait.

Parameters:
- RESET_PC, 32'h0000_0000, first fetch address after reset.
- NOP_INST, 32'h0000_0013, bubble instruction (addi x0,x0,0) driven on pipe_data.

Ports:
- clk  input  1  clock; all state updates on posedge.
- reset_n  input  1  reset, synchronous and active-low. One clock domain; polarity and synchronicity are fixed.
- stall  input  1  hold the IF/ID register and the PC (hazard unit).
- control_j  input  1  redirect request from decode.
- pc_j  input  32  redirect target from decode.
- imem_req  output  1  fetch request valid.
- imem_addr  output  32  fetch address; must be stable while imem_req=1 until imem_valid.
- imem_valid  input  1  response valid; completes the outstanding request.
- imem_data  input  32  instruction returned with imem_valid.
- pipe_pc  output  32  PC of the instruction in IF/ID.
- pipe_pc4  output  32  pipe_pc+4.
- pipe_data  output  32  instruction in IF/ID.
- pipe_valid  output  1  1 = pipe_data is a real fetched instruction.

Behaviour:
- Reset is sampled at posedge with reset_n=0. It sets:
  - pc_reg=RESET_PC, drop_addr=0, buf=0, state=FETCH
  - pipe_pc=0, pipe_pc4=0, pipe_data=NOP_INST, pipe_valid=0
  - imem_req is forced 0 while reset_n=0.
  - Reset mid-request abandons that request; any response arriving in the first FETCH cycle is treated as the response for RESET_PC. The memory model must therefore not carry stale responses across reset.
- State FETCH: imem_req=1, imem_addr=pc_reg.
  - control_j=1 and imem_valid=1: discard data; pc_reg<={pc_j[31:2],2'b00}; stay in FETCH.
  - control_j=1 and imem_valid=0: drop_addr<=pc_reg; pc_reg<=target; go to DROP.
  - imem_valid=1, stall=0: pipe_pc<=pc_reg, pipe_pc4<=pc_reg+4, pipe_data<=imem_data, pipe_valid<=1; pc_reg<=pc_reg+4.
  - imem_valid=1, stall=1: buf<=imem_data; go to HOLD; pipe outputs held.
  - imem_valid=0, stall=0: pipe_data<=NOP_INST, pipe_valid<=0; pipe_pc and pipe_pc4 held.
  - imem_valid=0, stall=1: pipe outputs held.
- State HOLD: imem_req=0.
  - control_j=1: buf discarded; pc_reg<=target; go to FETCH.
  - stall=0: load pipe with {pc_reg, pc_reg+4, buf}, pipe_valid<=1; pc_reg<=pc_reg+4; go to FETCH.
  - Otherwise: hold.
- State DROP: imem_req=1, imem_addr=drop_addr (the old request is kept stable).
  - control_j=1: pc_reg<=new target (latest redirect wins).
  - imem_valid=1: data discarded; go to FETCH.
- Redirect flush: any control_j=1 cycle forces pipe_data<=NOP_INST and pipe_valid<=0. control_j has priority over stall.
- Latency: a zero-wait memory (imem_valid the same cycle as imem_req) gives 1 instruction per cycle. The instruction appears on the pipe outputs 1 cycle after its request is accepted.
- Arithmetic: all PC sums are modulo 2^32. pc_reg=32'hFFFF_FFFC gives pipe_pc4=0 and next pc_reg=0. pc_j[1:0] are ignored.
- At most one request is outstanding; no new address is issued before imem_valid.

Test Plan:
- Reset, zero-wait memory returning addr+0x100 as data -> first pipe_pc=0, pipe_pc4=4, pipe_data=0x100, pipe_valid=1. Then pipe_pc increments 4, 8, 0xC on consecutive cycles; pipe_data=NOP_INST/pipe_valid=0 while reset_n=0.
- Memory with 2 wait cycles -> two NOP bubbles (pipe_valid=0) between instructions; imem_addr stable at 0x8 during the wait.
- stall=1 for 3 cycles while the response for 0x10 arrives -> pipe outputs frozen, imem_req=0. After release, pipe_pc=0x10 with the buffered data, then fetch resumes at 0x14.
- control_j=1, pc_j=0x40 while a 3-wait request to 0x20 is pending -> NOP flushed, imem_addr stays 0x20 until valid, data discarded. Next request is at 0x40; pipe_pc=0x40 follows.
- control_j=1 with pc_j=0x80 and stall=1 in the same cycle, in HOLD -> NOP, buffer dropped, next imem_addr=0x80.
- RESET_PC=32'hFFFF_FFFC -> first pipe_pc4=0, second fetch address 0x0. Reset asserted mid-DROP -> state FETCH at RESET_PC, pipe_valid=0.
